// File: rtl/pipe_ctl_pkg.sv
// rtl/pipe_ctl_pkg.sv - shared types and constants for the pipeline controller
// Purpose: FSM state encoding, PC width and default flush length used by
//          pipe_ctl and flush_cnt.
// Ports:   none (package).
package pipe_ctl_pkg;

  localparam int PC_W             = 64;
  localparam int FLUSH_CYCLES_DEF = 2;
  localparam int CNT_W            = 2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_FENCE = 2'd3
  } state_e;

endpackage

// File: rtl/flush_cnt.sv
// rtl/flush_cnt.sv - loadable down-counter with zero flag
// Purpose: counts the remaining IF/ID clear cycles after a redirect.
// Ports:   clk, rst_n (async active-low), load_i/load_val_i (load value),
//          dec_i (decrement, saturates at 0), zero_o (count is 0).
module flush_cnt
  import pipe_ctl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_ctl.sv
// rtl/pipe_ctl.sv - pipeline stall/flush/redirect controller
// Purpose: decides stalls, bubbles and PC redirects for the IF/ID and ID/EX
//          registers from hazards, branches, traps and (optionally) fence.i.
// Config:  macro FENCE_I_EN adds fence_i, fence_pc, ic_inv_done, ic_inv_req.
// Ports:   clk, rst_n (async active-low); if_busy, mem_busy, load_use;
//          bj_en/bj_pc, trap_en/trap_pc; stall/clear for IF/ID and ID/EX;
//          redir_en/redir_pc one-cycle redirect; state_o debug state.
module pipe_ctl
  import pipe_ctl_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_busy,
  input  logic            mem_busy,
  input  logic            load_use,
  input  logic            bj_en,
  input  logic [PC_W-1:0] bj_pc,
  input  logic            trap_en,
  input  logic [PC_W-1:0] trap_pc,
`ifdef FENCE_I_EN
  input  logic            fence_i,
  input  logic [PC_W-1:0] fence_pc,
  input  logic            ic_inv_done,
  output logic            ic_inv_req,
`endif
  output logic            stall_if_id,
  output logic            clear_if_id,
  output logic            stall_id_ex,
  output logic            clear_id_ex,
  output logic            redir_en,
  output logic [PC_W-1:0] redir_pc,
  output logic [1:0]      state_o
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            cnt_load, cnt_dec, cnt_zero;
  logic            go;
  logic [PC_W-1:0] go_pc;
  logic            s_ifid, c_ifid, s_idex, c_idex;
`ifdef FENCE_I_EN
  logic            inv_req;
`endif

  flush_cnt u_flush_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (CNT_W'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0)),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    go       = 1'b0;
    go_pc    = '0;
    s_ifid   = 1'b0;
    c_ifid   = 1'b0;
    s_idex   = 1'b0;
    c_idex   = 1'b0;
`ifdef FENCE_I_EN
    inv_req  = 1'b0;
`endif
    case (state_q)
      ST_RUN: begin
        if (trap_en) begin
          if (!mem_busy) begin
            go    = 1'b1;
            go_pc = trap_pc;
          end else begin
            pc_d    = trap_pc;
            s_ifid  = 1'b1;
            s_idex  = 1'b1;
            state_d = ST_DRAIN;
          end
        end else if (bj_en) begin
          go    = 1'b1;
          go_pc = bj_pc;
`ifdef FENCE_I_EN
        end else if (fence_i) begin
          inv_req = 1'b1;
          s_ifid  = 1'b1;
          s_idex  = 1'b1;
          pc_d    = fence_pc;
          state_d = ST_FENCE;
`endif
        end else if (load_use) begin
          s_ifid = 1'b1;
          c_idex = 1'b1;
        end else if (if_busy || mem_busy) begin
          s_ifid = 1'b1;
          s_idex = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Redirect only once the outstanding access retires; new
        // traps/branches here are wrong-path and dropped.
        if (mem_busy) begin
          s_ifid = 1'b1;
          s_idex = 1'b1;
        end else begin
          go    = 1'b1;
          go_pc = pc_q;
        end
      end
      ST_FLUSH: begin
        c_ifid = 1'b1;
        s_idex = mem_busy;
        if (trap_en) begin
          if (!mem_busy) begin
            go    = 1'b1;
            go_pc = trap_pc;
          end else begin
            pc_d    = trap_pc;
            s_ifid  = 1'b1;
            s_idex  = 1'b1;
            state_d = ST_DRAIN;
          end
        end else if (cnt_zero) begin
          state_d = ST_RUN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
`ifdef FENCE_I_EN
      ST_FENCE: begin
        if (ic_inv_done) begin
          go    = 1'b1;
          go_pc = pc_q + PC_W'(4);
        end else begin
          inv_req = 1'b1;
          s_ifid  = 1'b1;
          s_idex  = 1'b1;
        end
      end
`endif
      default: state_d = ST_RUN;
    endcase

    // Redirect cycle itself is the first IF/ID clear cycle.
    if (go) begin
      c_ifid = 1'b1;
      c_idex = 1'b1;
      s_idex = 1'b0;
      if (FLUSH_CYCLES > 1) begin
        state_d  = ST_FLUSH;
        cnt_load = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Outputs are forced low while reset is held, regardless of inputs.
  assign stall_if_id = rst_n & s_ifid & ~c_ifid;
  assign clear_if_id = rst_n & c_ifid;
  assign stall_id_ex = rst_n & s_idex & ~c_idex;
  assign clear_id_ex = rst_n & c_idex;
  assign redir_en    = rst_n & go;
  assign redir_pc    = (rst_n && go) ? go_pc : '0;
  assign state_o     = state_q;
`ifdef FENCE_I_EN
  assign ic_inv_req  = rst_n & inv_req;
`endif

endmodule

// File: tb/tb_pipe_ctl.sv
// tb/tb_pipe_ctl.sv - directed self-checking bench for pipe_ctl
module tb_pipe_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_busy, mem_busy, load_use, bj_en, trap_en;
  logic [63:0] bj_pc, trap_pc;
  logic        stall_if_id, clear_if_id, stall_id_ex, clear_id_ex, redir_en;
  logic [63:0] redir_pc;
  logic [1:0]  state_o;
`ifdef FENCE_I_EN
  logic        fence_i, ic_inv_done, ic_inv_req;
  logic [63:0] fence_pc;
`endif

  int n_vec = 0;
  int n_err = 0;

  localparam logic [4:0] C_IDLE  = 5'b00000;
  localparam logic [4:0] C_REDIR = 5'b01011;
  localparam logic [4:0] C_STALL = 5'b10100;
  localparam logic [4:0] C_LU    = 5'b10010;
  localparam logic [4:0] C_FL    = 5'b01000;

  always #5 clk = ~clk;

  pipe_ctl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_busy     (if_busy),
    .mem_busy    (mem_busy),
    .load_use    (load_use),
    .bj_en       (bj_en),
    .bj_pc       (bj_pc),
    .trap_en     (trap_en),
    .trap_pc     (trap_pc),
`ifdef FENCE_I_EN
    .fence_i     (fence_i),
    .fence_pc    (fence_pc),
    .ic_inv_done (ic_inv_done),
    .ic_inv_req  (ic_inv_req),
`endif
    .stall_if_id (stall_if_id),
    .clear_if_id (clear_if_id),
    .stall_id_ex (stall_id_ex),
    .clear_id_ex (clear_id_ex),
    .redir_en    (redir_en),
    .redir_pc    (redir_pc),
    .state_o     (state_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ctl = {stall_if_id, clear_if_id, stall_id_ex, clear_id_ex, redir_en}
  task automatic expect_out(input string tag, input logic [4:0] ctl,
                            input logic [63:0] pc, input logic [1:0] st);
    chk({tag, ".ctl"}, {59'd0, stall_if_id, clear_if_id, stall_id_ex, clear_id_ex, redir_en}, {59'd0, ctl});
    chk({tag, ".pc"}, redir_pc, pc);
    chk({tag, ".st"}, {62'd0, state_o}, {62'd0, st});
  endtask

  task automatic idle_in();
    if_busy = 0; mem_busy = 0; load_use = 0; bj_en = 0; trap_en = 0;
    bj_pc = '0; trap_pc = '0;
`ifdef FENCE_I_EN
    fence_i = 0; ic_inv_done = 0; fence_pc = '0;
`endif
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    if_busy = 1; load_use = 1; bj_en = 1; bj_pc = 64'h1234;
    #2;
    expect_out("reset", C_IDLE, 64'h0, 2'd0);
    nxt(); nxt();
    rst_n = 1'b1;
    idle_in();
    #1 expect_out("run_idle", C_IDLE, 64'h0, 2'd0);

    // Branch redirect, bj_en ignored during FLUSH
    nxt(); bj_en = 1; bj_pc = 64'h8000_0100;
    #1 expect_out("bj", C_REDIR, 64'h8000_0100, 2'd0);
    nxt(); bj_pc = 64'h8000_0200;
    #1 expect_out("bj_flush", C_FL, 64'h0, 2'd2);
    nxt(); idle_in();
    #1 expect_out("bj_back", C_IDLE, 64'h0, 2'd0);

    // Load-use bubble, then fetch busy stall
    nxt(); load_use = 1;
    #1 expect_out("load_use", C_LU, 64'h0, 2'd0);
    nxt(); load_use = 0; if_busy = 1;
    #1 expect_out("if_busy", C_STALL, 64'h0, 2'd0);
    nxt(); if_busy = 0;
    #1 expect_out("busy_done", C_IDLE, 64'h0, 2'd0);

    // Trap beats branch in the same cycle
    nxt(); trap_en = 1; trap_pc = 64'h8000_0000; bj_en = 1; bj_pc = 64'h8000_0100;
    #1 expect_out("trap_bj", C_REDIR, 64'h8000_0000, 2'd0);
    nxt(); idle_in();
    #1 expect_out("trap_fl", C_FL, 64'h0, 2'd2);
    nxt();

    // Trap with memory busy: drain 3 cycles, redirect on the 4th
    nxt(); trap_en = 1; trap_pc = 64'h8000_0000; mem_busy = 1;
    #1 expect_out("drain0", C_STALL, 64'h0, 2'd0);
    nxt(); trap_pc = 64'hdead_0000; bj_en = 1; bj_pc = 64'hbeef_0000;
    #1 expect_out("drain1", C_STALL, 64'h0, 2'd1);
    nxt();
    #1 expect_out("drain2", C_STALL, 64'h0, 2'd1);
    nxt(); mem_busy = 0;
    #1 expect_out("drain_redir", C_REDIR, 64'h8000_0000, 2'd1);
    nxt(); idle_in();
    #1 expect_out("drain_fl", C_FL, 64'h0, 2'd2);

    // Trap during FLUSH restarts the redirect
    nxt(); bj_en = 1; bj_pc = 64'h40;
    #1 expect_out("bj2", C_REDIR, 64'h40, 2'd0);
    nxt(); bj_en = 0; trap_en = 1; trap_pc = 64'h80;
    #1 expect_out("fl_trap", C_REDIR, 64'h80, 2'd2);
    nxt(); idle_in();
    #1 expect_out("fl_trap_fl", C_FL, 64'h0, 2'd2);

    // Reset in the middle of FLUSH
    nxt(); bj_en = 1; bj_pc = 64'hc0;
    nxt(); bj_en = 0; if_busy = 1;
    #1 expect_out("pre_rst", C_FL, 64'h0, 2'd2);
    rst_n = 1'b0;
    #1 expect_out("mid_rst", C_IDLE, 64'h0, 2'd0);
    nxt(); rst_n = 1'b1; if_busy = 0;
    #1 expect_out("post_rst0", C_IDLE, 64'h0, 2'd0);
    nxt();
    #1 expect_out("post_rst1", C_IDLE, 64'h0, 2'd0);

`ifdef FENCE_I_EN
    nxt(); fence_i = 1; fence_pc = 64'h100;
    #1 expect_out("fence0", C_STALL, 64'h0, 2'd0);
    chk("fence0.req", {63'd0, ic_inv_req}, 64'd1);
    for (int i = 1; i < 5; i++) begin
      nxt(); fence_i = 0; fence_pc = 64'h0;
      #1 expect_out("fence_wait", C_STALL, 64'h0, 2'd3);
      chk("fence_wait.req", {63'd0, ic_inv_req}, 64'd1);
    end
    nxt(); ic_inv_done = 1;
    #1 expect_out("fence_done", C_REDIR, 64'h104, 2'd3);
    chk("fence_done.req", {63'd0, ic_inv_req}, 64'd0);
    nxt(); idle_in();
    #1 expect_out("fence_fl", C_FL, 64'h0, 2'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctl.md
PIPE_CTL -- requirements
Module: pipe_ctl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2: number of cycles the IF/ID register is cleared after any redirect; range 1..3.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 if_busy  in  1  fetch unit waiting on instruction bus.
REQ-005 mem_busy  in  1  memory stage has an outstanding data access.
REQ-006 load_use  in  1  ID instruction depends on a load in EX.
REQ-007 bj_en, bj_pc  in  1, 64  branch/jump taken in EX, and its target.
REQ-008 trap_en, trap_pc  in  1, 64  trap raised, and its handler address.
REQ-009 stall_if_id, clear_if_id  out  1, 1  hold/bubble the IF/ID register.
REQ-010 stall_id_ex, clear_id_ex  out  1, 1  hold/bubble the ID/EX register.
REQ-011 redir_en, redir_pc  out  1, 64  one-cycle PC redirect to fetch.
REQ-012 state_o  out  2  current FSM state, for debug.

Function
REQ-013 FSM states: RUN=0, DRAIN=1, FLUSH=2, FENCE=3 (FENCE only with macro).
REQ-014 RUN, priority trap_en > bj_en > fence_i > load_use > if_busy/mem_busy.
REQ-015 RUN with trap_en and mem_busy=0: same cycle redir_en=1, redir_pc=trap_pc, clear_if_id=clear_id_ex=1; next state FLUSH.
REQ-016 RUN with trap_en and mem_busy=1: latch trap_pc; stall both registers; next state DRAIN.
REQ-017 DRAIN: stall both registers until mem_busy=0; in that cycle redirect to the latched pc, clear both registers; next state FLUSH. Further trap_en/bj_en in DRAIN are ignored.
REQ-018 RUN with bj_en (no trap): redir_en=1, redir_pc=bj_pc, clear_if_id=clear_id_ex=1; next state FLUSH.
REQ-019 FLUSH: clear_if_id=1 for FLUSH_CYCLES-1 further cycles via a down-counter; then return to RUN. A trap_en during FLUSH restarts per REQ-015/016; bj_en during FLUSH is ignored.
REQ-020 RUN with load_use: stall_if_id=1, clear_id_ex=1 (one bubble), no redirect.
REQ-021 RUN with if_busy or mem_busy: stall_if_id=stall_id_ex=1.
REQ-022 clear has precedence over stall on the same register; stall and clear are never both 1 on one register.
REQ-023 redir_en is asserted for exactly one cycle per redirect.
REQ-024 All outputs are combinational from state, counter and inputs; state, counter and latched pc are registered.

Reset
REQ-025 Asynchronous assert on rst_n=0: state=RUN, counter=0, latched pc=0.
REQ-026 During reset all stall/clear/redir outputs are 0 and redir_pc is 0; reset mid-DRAIN/FLUSH discards the pending redirect.

Configuration
REQ-027 Macro FENCE_I_EN: adds inputs fence_i (ID holds fence.i) and ic_inv_done (icache invalidate complete), and output ic_inv_req.
REQ-028 With FENCE_I_EN, fence_i in RUN: ic_inv_req=1, stall both registers, go to FENCE; on ic_inv_done, redirect to fence_pc+4 (new input fence_pc, 64), clear both, go to FLUSH.
REQ-029 Without FENCE_I_EN: the ports are absent, FENCE is unreachable, and fence.i is treated as a nop.

Structure
REQ-030 Shared package holds the state enum, FLUSH_CYCLES default and the 64-bit PC width constant.
REQ-031 One sub-module, flush_cnt: loadable down-counter with zero flag.

Verification
REQ-032 bj_en=1, bj_pc=0x8000_0100 in RUN -> same cycle redir_en=1, pc 0x8000_0100, both clears=1; clear_if_id high 2 cycles total; back to RUN.
REQ-033 trap_en=1, trap_pc=0x8000_0000 with mem_busy=1 for 3 cycles -> 3 cycles DRAIN with stalls; redirect on 4th cycle; then FLUSH.
REQ-034 trap_en and bj_en in the same cycle -> redir_pc=trap_pc.
REQ-035 load_use=1 one cycle -> stall_if_id=1, clear_id_ex=1, redir_en=0.
REQ-036 rst_n low during FLUSH -> outputs 0 immediately, state_o=0, no redirect after release.
REQ-037 With FENCE_I_EN, fence_i at fence_pc 0x100, ic_inv_done after 5 cycles -> ic_inv_req for 5 cycles, redirect to 0x104.
